// File: rtl/window_peak_tracker_pkg.sv
// Shared types and constants for the windowed peak/amplitude tracker.
// Optional build macro used by the design: WINDOW_PEAK_TRACKER_ABS_SUM_EN.
package window_peak_tracker_pkg;

  localparam int DEFAULT_WIDTH     = 14;
  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam int MIN_WINDOW        = 1;

  typedef enum logic {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [DEFAULT_WIDTH-1:0]                   maxVal;
    logic signed [DEFAULT_WIDTH-1:0]                   minVal;
    logic        [DEFAULT_WIDTH+DEFAULT_CNT_WIDTH-1:0] absSum;
  } result_t;

endpackage

// File: rtl/window_peak_tracker_signed_abs.sv
// Combinational signed-to-unsigned magnitude. The most negative input maps to
// 2^(WIDTH-1), which still fits in WIDTH unsigned bits, so nothing is clipped.
module signed_abs #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] mag
);

  // Two's-complement negate when the sign bit is set.
  always_comb begin
    mag = a;
    if (a[WIDTH-1]) begin
      mag = ~a + 1'b1;
    end
  end

endmodule

// File: rtl/window_peak_tracker.sv
// Per-window maximum, minimum and sum of |x| over a programmable number of
// enabled samples, handed to the consumer through a valid/ready register stage.
// Build macro: WINDOW_PEAK_TRACKER_ABS_SUM_EN enables the |x| accumulator and
// the outAbsSum register; without it outAbsSum is tied to zero.
module window_peak_tracker
  import window_peak_tracker_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           x,
  input  logic [CNT_WIDTH-1:0]       windowLength,
  input  logic                       clear,
  input  logic                       outReady,
  output logic                       outValid,
  output logic [WIDTH-1:0]           outMax,
  output logic [WIDTH-1:0]           outMin,
  output logic [WIDTH+CNT_WIDTH-1:0] outAbsSum,
  output logic                       overrun
);

  localparam logic [CNT_WIDTH-1:0] MIN_LEN = CNT_WIDTH'(MIN_WINDOW);

  state_t                    state;
  state_t                    stateNext;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      cntNext;
  logic [CNT_WIDTH-1:0]      len;
  logic [CNT_WIDTH-1:0]      lenEff;
  logic signed [WIDTH-1:0]   xs;
  logic signed [WIDTH-1:0]   maxReg;
  logic signed [WIDTH-1:0]   minReg;
  logic signed [WIDTH-1:0]   maxNext;
  logic signed [WIDTH-1:0]   minNext;
  logic                      complete;
  logic                      sampleTaken;

  assign xs          = x;
  assign lenEff      = (windowLength < MIN_LEN) ? MIN_LEN : windowLength;
  assign sampleTaken = enable && !clear;

  // Window sequencing and the statistics the current sample would produce.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    maxNext   = maxReg;
    minNext   = minReg;
    complete  = 1'b0;
    unique case (state)
      FIRST: begin
        if (enable) begin
          maxNext = xs;
          minNext = xs;
          cntNext = MIN_LEN;
          if (lenEff == MIN_LEN) begin
            complete = 1'b1;
          end else begin
            stateNext = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (enable) begin
          if (xs > maxReg) begin
            maxNext = xs;
          end
          if (xs < minReg) begin
            minNext = xs;
          end
          cntNext = cnt + 1'b1;
          if (cntNext == len) begin
            complete  = 1'b1;
            stateNext = FIRST;
          end
        end
      end
    endcase
    if (clear) begin
      stateNext = FIRST;
      complete  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
    end else begin
      state <= stateNext;
    end
  end

  // Running max/min/count; the window length is captured on the first sample only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      len    <= '0;
      maxReg <= '0;
      minReg <= '0;
    end else if (sampleTaken) begin
      cnt    <= cntNext;
      maxReg <= maxNext;
      minReg <= minNext;
      if (state == FIRST) begin
        len <= lenEff;
      end
    end
  end

  // Result handshake: load on completion, drop on transfer, flag unconsumed overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      overrun  <= 1'b0;
      outMax   <= '0;
      outMin   <= '0;
    end else if (clear) begin
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else if (complete) begin
      outValid <= 1'b1;
      outMax   <= maxNext;
      outMin   <= minNext;
      if (outValid && !outReady) begin
        overrun <= 1'b1;
      end
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

`ifdef WINDOW_PEAK_TRACKER_ABS_SUM_EN
  logic [WIDTH-1:0]           absX;
  logic [WIDTH+CNT_WIDTH-1:0] accReg;
  logic [WIDTH+CNT_WIDTH-1:0] accNext;
  logic [WIDTH+CNT_WIDTH-1:0] absSumReg;

  signed_abs #(
    .WIDTH(WIDTH)
  ) uAbs (
    .a  (x),
    .mag(absX)
  );

  // Magnitude accumulation: restart on the first sample, add on later ones.
  always_comb begin
    accNext = accReg;
    if (state == FIRST) begin
      accNext = {{CNT_WIDTH{1'b0}}, absX};
    end else begin
      accNext = accReg + {{CNT_WIDTH{1'b0}}, absX};
    end
  end

  // Accumulator register plus its copy in the result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accReg    <= '0;
      absSumReg <= '0;
    end else begin
      if (sampleTaken) begin
        accReg <= accNext;
      end
      if (complete) begin
        absSumReg <= accNext;
      end
    end
  end

  assign outAbsSum = absSumReg;
`else
  assign outAbsSum = '0;
`endif

endmodule
